seq_detect_ctrl: RTL

//  Controller for a programmable serial pattern detector (1..PAT_W bits).

---
 rtl/seq_detect_pkg.sv | 21 ++
 rtl/seq_detect_if.sv | 33 +++
 rtl/seq_shift_matcher.sv | 48 ++++
 rtl/seq_detect_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: FSM encodings and default widths.
package seq_detect_pkg;

  localparam int unsigned DefPatW = 8;
  localparam int unsigned DefCntW = 8;

  // Wide enough to hold a length value of pat_w itself.
  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam int unsigned DefLenW = len_width(DefPatW);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/seq_detect_if.sv
// Config, control, serial input and status signals of the pattern detector.
interface seq_detect_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 4
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_thresh;
  logic             start;
  logic             abort;
  logic             din;
  logic             din_valid;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    output start, abort, din, din_valid,
    input  match, match_cnt, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    input  start, abort, din, din_valid,
    output match, match_cnt, busy, done, cfg_err
  );
endinterface

// File: rtl/seq_shift_matcher.sv
// History shift register and fill counter; flags a hit when the bit being shifted in
// completes the masked pattern.
module seq_shift_matcher #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_d, mask;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W:0]   fill_inc;
  logic             filled;

  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], din};
    fill_inc = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    filled   = (fill_inc >= {1'b0, len});
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len));
    end
    hit    = shift && filled && (((hist_d ^ pattern) & mask) == '0);
    fill_d = filled ? len : fill_inc[LEN_W-1:0];
    // Non-overlapping mode needs a full fresh pattern after every hit.
    if (hit && !overlap) begin
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector controller: cfg registers, IDLE/ARM/RUN/DONE
// sequencing, match counter and registered status outputs.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned LEN_W = DefLenW
) (
  input logic        clk,
  input logic        rst,
  seq_detect_if.slave bus
);

  state_e           state_q;
  logic [PAT_W-1:0] cfg_pattern_q;
  logic [LEN_W-1:0] cfg_len_q;
  logic             cfg_overlap_q;
  logic [CNT_W-1:0] cfg_thresh_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic             match_q, busy_q, done_q, cfg_err_q;

  logic cfg_legal, arm_go, clear, shift, hit, cnt_last;

  always_comb begin
    cfg_legal = (cfg_len_q != '0) && (cfg_len_q <= LEN_W'(PAT_W)) && (cfg_thresh_q != '0);
    arm_go    = !bus.abort && bus.start &&
                (((state_q == StIdle) && cfg_legal) || (state_q == StDone));
    clear     = arm_go || (state_q == StArm);
    // abort blocks the shift so a completing bit is neither matched nor counted.
    shift     = (state_q == StRun) && bus.din_valid && !bus.abort;
    cnt_last  = ((match_cnt_q + CNT_W'(1)) == cfg_thresh_q);
  end

  seq_shift_matcher #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_matcher (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .shift  (shift),
    .din    (bus.din),
    .pattern(cfg_pattern_q),
    .len    (cfg_len_q),
    .overlap(cfg_overlap_q),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cfg_pattern_q <= '0;
      cfg_len_q     <= '0;
      cfg_overlap_q <= 1'b0;
      cfg_thresh_q  <= '0;
      match_cnt_q   <= '0;
      match_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      if (bus.abort) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.cfg_we) begin
              cfg_pattern_q <= bus.cfg_pattern;
              cfg_len_q     <= bus.cfg_len;
              cfg_overlap_q <= bus.cfg_overlap;
              cfg_thresh_q  <= bus.cfg_thresh;
            end
            if (bus.start) begin
              if (arm_go) begin
                state_q     <= StArm;
                busy_q      <= 1'b1;
                match_cnt_q <= '0;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          StArm: begin
            state_q <= StRun;
          end
          StRun: begin
            if (hit) begin
              match_q     <= 1'b1;
              match_cnt_q <= match_cnt_q + CNT_W'(1);
              if (cnt_last) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          StDone: begin
            if (bus.start) begin
              state_q     <= StArm;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              match_cnt_q <= '0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
